shift_ring_counter: RTL and testbench

// - Parametrised N-bit shift counter running as a one-hot ring or a twisted-ring (Johnson) counter.
// - Runtime mode, direction, enable and seed load; position index and wrap pulse outputs.
// - Optional detection and auto-correction of illegal states.
// - Drives phase/sequencer timing in the sequential-circuits library.

---
 rtl/shift_ring_counter_pkg.sv | 14 +
 rtl/shift_ring_counter_if.sv | 30 +++
 rtl/src_legal_check.sv | 33 +++
 rtl/shift_ring_counter.sv | 93 +++++++++
 tb/tb_shift_ring_counter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/shift_ring_counter_pkg.sv
// Shared types and helpers for the shift/ring counter.
// - mode_t: ring (one-hot) or Johnson (twisted ring) operation.
// - dir_t:  shift direction.
// - period(): number of distinct states in a full cycle for a given width and mode.
package shift_ring_counter_pkg;

  typedef enum logic {RING, JOHNSON} mode_t;
  typedef enum logic {LEFT, RIGHT} dir_t;

  function automatic int unsigned period(int unsigned n, mode_t mode);
    return (mode == JOHNSON) ? 2 * n : n;
  endfunction

endpackage

// File: rtl/shift_ring_counter_if.sv
// Control and status bundle of the shift/ring counter.
// master: drives en, mode, dir, load, seed; observes q, pos, wrap, illegal, err.
// slave:  the counter side of the same signals.
interface shift_ring_counter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned PW = $clog2(2 * N);

  logic          en;
  logic          mode;
  logic          dir;
  logic          load;
  logic [N-1:0]  seed;
  logic [N-1:0]  q;
  logic [PW-1:0] pos;
  logic          wrap;
  logic          illegal;
  logic          err;

  modport master (
    output en, mode, dir, load, seed,
    input  q, pos, wrap, illegal, err
  );

  modport slave (
    input  en, mode, dir, load, seed,
    output q, pos, wrap, illegal, err
  );

endinterface

// File: rtl/src_legal_check.sv
// Combinational legality check of a counter state.
// Ports:
//   q       in   N   counter state
//   mode    in   1   mode the state is judged against
//   illegal out  1   ring: not exactly one bit set;
//                    Johnson: more than one adjacent-bit transition
module src_legal_check
  import shift_ring_counter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] q,
  input  mode_t        mode,
  output logic         illegal
);

  int unsigned ones;
  int unsigned edges;

  always_comb begin
    ones  = 0;
    edges = 0;
    for (int unsigned i = 0; i < N; i++) begin
      ones = ones + 32'(q[i]);
    end
    // A legal Johnson word is a single run of ones and a single run of zeros.
    for (int unsigned i = 1; i < N; i++) begin
      edges = edges + 32'(q[i] ^ q[i-1]);
    end
    illegal = (mode == RING) ? (ones != 1) : (edges > 1);
  end

endmodule

// File: rtl/shift_ring_counter.sv
// N-bit shift counter: one-hot ring or Johnson, runtime mode/direction, seed load,
// position index with wrap pulse, and optional illegal-state auto-correction.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset to the init state (q = 1, pos = 0)
//   bus  slave modport: en, mode, dir, load, seed in; q, pos, wrap, illegal, err out
module shift_ring_counter
  import shift_ring_counter_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter bit          AUTOCORRECT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_ring_counter_if.slave   bus
);

  localparam int unsigned PW = $clog2(2 * N);

  logic [N-1:0]  q_q;
  logic [PW-1:0] pos_q;
  logic          wrap_q;
  logic          err_q;
  mode_t         mode_q;
  logic          illegal;
  logic [PW-1:0] pos_last;
  mode_t         mode_in;
  dir_t          dir_in;

  assign mode_in  = mode_t'(bus.mode);
  assign dir_in   = dir_t'(bus.dir);
  assign pos_last = PW'(period(N, mode_q) - 1);

  // Legality is judged against the adopted mode, not the raw mode input.
  src_legal_check #(
    .N (N)
  ) u_legal (
    .q       (q_q),
    .mode    (mode_q),
    .illegal (illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= N'(1);
      pos_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= mode_in;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.load) begin
        q_q    <= bus.seed;
        pos_q  <= '0;
        mode_q <= mode_in;
      end else if (mode_in != mode_q) begin
        q_q    <= N'(1);
        pos_q  <= '0;
        mode_q <= mode_in;
      end else if (bus.en && illegal && AUTOCORRECT) begin
        q_q   <= N'(1);
        pos_q <= '0;
        err_q <= 1'b1;
      end else if (bus.en) begin
        if (dir_in == LEFT) begin
          q_q <= {q_q[N-2:0], (mode_q == JOHNSON) ? ~q_q[N-1] : q_q[N-1]};
          if (pos_q == pos_last) begin
            pos_q  <= '0;
            wrap_q <= 1'b1;
          end else begin
            pos_q <= pos_q + PW'(1);
          end
        end else begin
          q_q <= {(mode_q == JOHNSON) ? ~q_q[0] : q_q[0], q_q[N-1:1]};
          if (pos_q == '0) begin
            pos_q  <= pos_last;
            wrap_q <= 1'b1;
          end else begin
            pos_q <= pos_q - PW'(1);
          end
        end
      end
    end
  end

  assign bus.q       = q_q;
  assign bus.pos     = pos_q;
  assign bus.wrap    = wrap_q;
  assign bus.err     = err_q;
  assign bus.illegal = illegal;

endmodule

// File: tb/tb_shift_ring_counter.sv
// Scoreboard bench for shift_ring_counter (N = 4). Two instances share stimulus:
// u_dut1 with auto-correction, u_dut0 without.
module tb_shift_ring_counter;

  logic clk;
  logic rst;

  shift_ring_counter_if #(.N(4)) u_if1 ();
  shift_ring_counter_if #(.N(4)) u_if0 ();

  assign u_if0.en   = u_if1.en;
  assign u_if0.mode = u_if1.mode;
  assign u_if0.dir  = u_if1.dir;
  assign u_if0.load = u_if1.load;
  assign u_if0.seed = u_if1.seed;

  shift_ring_counter #(.N(4), .AUTOCORRECT(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1)
  );

  shift_ring_counter #(.N(4), .AUTOCORRECT(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (u_if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         inst;
    logic [3:0] q;
    logic [2:0] pos;
    logic       wrap;
    logic       err;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  event sample_now;

  task automatic push(input string name, input bit inst, input logic [3:0] q,
                      input logic [2:0] pos, input logic wrap, input logic err,
                      input logic ill);
    exp_t e;
    e.name = name; e.inst = inst; e.q = q; e.pos = pos;
    e.wrap = wrap; e.err = err; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input string field, input logic [3:0] act,
                     input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s.%s: got %b, expected %b", name, field, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the step lands on the next edge.
  task automatic step(input logic e, input logic m, input logic d, input logic l,
                      input logic [3:0] s);
    u_if1.en = e; u_if1.mode = m; u_if1.dir = d; u_if1.load = l; u_if1.seed = s;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation at the falling edge (or on demand).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_now);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.inst) begin
          chk(e.name, "q",       u_if1.q,              e.q);
          chk(e.name, "pos",     {1'b0, u_if1.pos},    {1'b0, e.pos});
          chk(e.name, "wrap",    {3'b0, u_if1.wrap},   {3'b0, e.wrap});
          chk(e.name, "err",     {3'b0, u_if1.err},    {3'b0, e.err});
          chk(e.name, "illegal", {3'b0, u_if1.illegal}, {3'b0, e.ill});
        end else begin
          chk(e.name, "q",       u_if0.q,              e.q);
          chk(e.name, "pos",     {1'b0, u_if0.pos},    {1'b0, e.pos});
          chk(e.name, "wrap",    {3'b0, u_if0.wrap},   {3'b0, e.wrap});
          chk(e.name, "err",     {3'b0, u_if0.err},    {3'b0, e.err});
          chk(e.name, "illegal", {3'b0, u_if0.illegal}, {3'b0, e.ill});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    u_if1.en = 1'b0; u_if1.mode = 1'b0; u_if1.dir = 1'b0;
    u_if1.load = 1'b0; u_if1.seed = 4'b0000;
    @(posedge clk);
    #1;
    push("reset1", 1'b1, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0);
    push("reset0", 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Ring, left, four steps.
    step(1, 0, 0, 0, 4'b0000); push("ringl1", 1, 4'b0010, 3'd1, 0, 0, 0);
    step(1, 0, 0, 0, 4'b0000); push("ringl2", 1, 4'b0100, 3'd2, 0, 0, 0);
    step(1, 0, 0, 0, 4'b0000); push("ringl3", 1, 4'b1000, 3'd3, 0, 0, 0);
    step(1, 0, 0, 0, 4'b0000); push("ringl4", 1, 4'b0001, 3'd0, 1, 0, 0);

    // Switch to Johnson (reinit), then eight left steps.
    step(1, 1, 0, 0, 4'b0000); push("to_john", 1, 4'b0001, 3'd0, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnl1", 1, 4'b0011, 3'd1, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnl2", 1, 4'b0111, 3'd2, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnl3", 1, 4'b1111, 3'd3, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnl4", 1, 4'b1110, 3'd4, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnl5", 1, 4'b1100, 3'd5, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnl6", 1, 4'b1000, 3'd6, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnl7", 1, 4'b0000, 3'd7, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnl8", 1, 4'b0001, 3'd0, 1, 0, 0);

    // Back to ring with en low: mode change reinitialises anyway.
    step(0, 0, 0, 0, 4'b0000); push("to_ring", 1, 4'b0001, 3'd0, 0, 0, 0);
    step(1, 0, 1, 0, 4'b0000); push("ringr1", 1, 4'b1000, 3'd3, 1, 0, 0);
    step(0, 0, 1, 0, 4'b0000); push("hold1",  1, 4'b1000, 3'd3, 0, 0, 0);
    step(0, 0, 1, 0, 4'b0000); push("hold2",  1, 4'b1000, 3'd3, 0, 0, 0);
    step(0, 0, 1, 0, 4'b0000); push("hold3",  1, 4'b1000, 3'd3, 0, 0, 0);
    step(1, 0, 0, 0, 4'b0000); push("dirflip", 1, 4'b0001, 3'd0, 1, 0, 0);

    // Illegal ring seed: corrected with AUTOCORRECT, shifted without.
    step(0, 0, 0, 1, 4'b0110); push("ld_bad1", 1, 4'b0110, 3'd0, 0, 0, 1);
                               push("ld_bad0", 0, 4'b0110, 3'd0, 0, 0, 1);
    step(1, 0, 0, 0, 4'b0000); push("fix1", 1, 4'b0001, 3'd0, 0, 1, 0);
                               push("nofix0", 0, 4'b1100, 3'd1, 0, 0, 1);
    step(0, 0, 0, 0, 4'b0000); push("errclr1", 1, 4'b0001, 3'd0, 0, 0, 0);
                               push("hold0", 0, 4'b1100, 3'd1, 0, 0, 1);

    // Load wins over mode change and en; new mode adopted without later reinit.
    step(1, 1, 0, 1, 4'b0100); push("ld_mode", 1, 4'b0100, 3'd0, 0, 0, 1);
    step(0, 1, 0, 0, 4'b0000); push("no_reinit", 1, 4'b0100, 3'd0, 0, 0, 1);
    step(1, 1, 0, 0, 4'b0000); push("john_fix", 1, 4'b0001, 3'd0, 0, 1, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnb1", 1, 4'b0011, 3'd1, 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000); push("johnb2", 1, 4'b0111, 3'd2, 0, 0, 0);

    // Asynchronous reset between edges, checked before the next rising edge.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    push("async_rst", 1, 4'b0001, 3'd0, 0, 0, 0);
    ->sample_now;
    #1;
    rst = 1'b0;
    step(1, 1, 0, 0, 4'b0000); push("post_rst", 1, 4'b0011, 3'd1, 0, 0, 0);

    // Johnson right through the 0 -> PERIOD-1 boundary.
    step(1, 1, 1, 0, 4'b0000); push("johnr1", 1, 4'b0001, 3'd0, 0, 0, 0);
    step(1, 1, 1, 0, 4'b0000); push("johnr2", 1, 4'b0000, 3'd7, 1, 0, 0);

    @(negedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
